// File: rtl/pipelined_csa_multiplier.sv
// Pipelined carry-save array multiplier, unsigned or Baugh-Wooley signed per op.
// Ports: clk, rst, in_valid/in_ready, A, B, is_signed, out_valid/out_ready, C;
// acc_clr and ACC exist only when CSM_ACCUM_EN is defined.
module pipelined_csa_multiplier #(
  parameter int WIDTH       = 9,
  parameter int PIPE_STAGES = 3,
  parameter int ACC_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       A,
  input  logic [WIDTH-1:0]       B,
  input  logic                   is_signed,
`ifdef CSM_ACCUM_EN
  input  logic                   acc_clr,
  output logic [ACC_WIDTH-1:0]   ACC,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WIDTH-1:0]     C
);

  localparam int PW = 2 * WIDTH;
  localparam int NS = PIPE_STAGES;
  localparam int G  = (WIDTH + NS - 1) / NS;

  typedef logic [PW-1:0] prod_t;

  localparam prod_t ONE  = 1;
  // Baugh-Wooley correction: +2^W + 2^(2W-1)
  localparam prod_t CORR = (ONE << WIDTH) | (ONE << (PW - 1));

  if (WIDTH < 2 || NS < 1 || NS > WIDTH || ACC_WIDTH < PW) begin : g_bad
    $error("pipelined_csa_multiplier: bad parameters");
  end

  logic [NS-1:0]    v_q;
  logic [NS-1:0]    sg_q;
  logic [WIDTH-1:0] a_q   [NS];
  logic [WIDTH-1:0] b_q   [NS];
  prod_t            sum_q [NS];
  prod_t            car_q [NS];

  logic [NS-1:0]    nxt_v;
  logic [NS-1:0]    nxt_sg;
  logic [WIDTH-1:0] nxt_a   [NS];
  logic [WIDTH-1:0] nxt_b   [NS];
  prod_t            nxt_sum [NS];
  prod_t            nxt_car [NS];

  logic adv;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[NS-1];
  // Last stage register holds the carry-propagated product
  assign C         = sum_q[NS-1];

  function automatic prod_t pp_row(
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             sg,
    input int               r
  );
    prod_t row;
    logic  p;
    row = '0;
    for (int j = 0; j < WIDTH; j++) begin
      p = a[j] & b[r];
      if (sg && ((j == WIDTH - 1) != (r == WIDTH - 1)))
        p = !p;
      row[r+j] = p;
    end
    return row;
  endfunction

  always_comb begin : stage_comb
    prod_t            s;
    prod_t            c;
    prod_t            row;
    prod_t            cy;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sg;
    int               km;
    for (int k = 0; k < NS; k++) begin
      km = (k == 0) ? 0 : k - 1;
      if (k == 0) begin
        nxt_v[k] = in_valid;
        sg       = is_signed;
        a        = A;
        b        = B;
        s        = '0;
        c        = is_signed ? CORR : '0;
      end else begin
        nxt_v[k] = v_q[km];
        sg       = sg_q[km];
        a        = a_q[km];
        b        = b_q[km];
        s        = sum_q[km];
        c        = car_q[km];
      end
      for (int r = 0; r < WIDTH; r++) begin
        if (r / G == k) begin
          row = pp_row(a, b, sg, r);
          cy  = (s & c) | (s & row) | (c & row);
          s   = s ^ c ^ row;
          c   = cy << 1;
        end
      end
      nxt_sg[k]  = sg;
      nxt_a[k]   = a;
      nxt_b[k]   = b;
      nxt_sum[k] = s;
      nxt_car[k] = c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int k = 0; k < NS; k++) begin
        sum_q[k] <= '0;
        car_q[k] <= '0;
      end
    end else if (adv) begin
      v_q  <= nxt_v;
      sg_q <= nxt_sg;
      for (int k = 0; k < NS; k++) begin
        a_q[k]   <= nxt_a[k];
        b_q[k]   <= nxt_b[k];
        car_q[k] <= nxt_car[k];
        if (k == NS - 1)
          sum_q[k] <= nxt_sum[k] + nxt_car[k];
        else
          sum_q[k] <= nxt_sum[k];
      end
    end
  end

`ifdef CSM_ACCUM_EN
  logic [NS-1:0]        clr_q;
  logic [NS-1:0]        nxt_clr;
  logic [ACC_WIDTH-1:0] c_ext;

  always_comb begin
    int km;
    nxt_clr = '0;
    for (int k = 0; k < NS; k++) begin
      km = (k == 0) ? 0 : k - 1;
      nxt_clr[k] = (k == 0) ? acc_clr : clr_q[km];
    end
  end

  assign c_ext = sg_q[NS-1] ? ACC_WIDTH'($signed(C))
                            : ACC_WIDTH'(C);

  always_ff @(posedge clk) begin
    if (rst) begin
      clr_q <= '0;
      ACC   <= '0;
    end else begin
      if (adv)
        clr_q <= nxt_clr;
      if (out_valid && out_ready)
        ACC <= (clr_q[NS-1] ? '0 : ACC) + c_ext;
    end
  end
`endif

endmodule

// File: tb/tb_pipelined_csa_multiplier.sv
// Testbench for pipelined_csa_multiplier.
// Random and corner stimulus checked against an integer-arithmetic model.
module tb_pipelined_csa_multiplier;
  localparam int W  = 9;
  localparam int P  = 3;
  localparam int PW = 2 * W;

  typedef struct {
    logic [PW-1:0] c;
    int            cyc;
  } res_t;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          is_signed;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] C;
`ifdef CSM_ACCUM_EN
  logic [23:0]   ACC;
  logic [23:0]   acc1;
  logic [23:0]   acc9;
`endif

  logic          l_valid;
  logic [W-1:0]  l_a;
  logic [W-1:0]  l_b;
  logic          l1_rdy;
  logic          l1_ov;
  logic [PW-1:0] l1_c;
  logic          l9_rdy;
  logic          l9_ov;
  logic [PW-1:0] l9_c;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic rand_rdy;
  res_t got[$];

  pipelined_csa_multiplier #(.WIDTH(W), .PIPE_STAGES(P), .ACC_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .is_signed(is_signed),
`ifdef CSM_ACCUM_EN
    .acc_clr(acc_clr), .ACC(ACC),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .C(C)
  );

  pipelined_csa_multiplier #(.WIDTH(W), .PIPE_STAGES(1), .ACC_WIDTH(24)) dut_p1 (
    .clk(clk), .rst(rst), .in_valid(l_valid), .in_ready(l1_rdy),
    .A(l_a), .B(l_b), .is_signed(1'b0),
`ifdef CSM_ACCUM_EN
    .acc_clr(1'b0), .ACC(acc1),
`endif
    .out_valid(l1_ov), .out_ready(1'b1), .C(l1_c)
  );

  pipelined_csa_multiplier #(.WIDTH(W), .PIPE_STAGES(9), .ACC_WIDTH(24)) dut_p9 (
    .clk(clk), .rst(rst), .in_valid(l_valid), .in_ready(l9_rdy),
    .A(l_a), .B(l_b), .is_signed(1'b0),
`ifdef CSM_ACCUM_EN
    .acc_clr(1'b0), .ACC(acc9),
`endif
    .out_valid(l9_ov), .out_ready(1'b1), .C(l9_c)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (!rst && out_valid && out_ready)
      got.push_back('{C, cyc});

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  function automatic longint ival(input logic [W-1:0] v, input logic sg);
    longint x;
    x = v;
    if (sg && v[W-1]) x = x - (longint'(1) << W);
    return x;
  endfunction

  function automatic logic [PW-1:0] ref_mul(
    input logic [W-1:0] a, input logic [W-1:0] b, input logic sg
  );
    longint p;
    p = ival(a, sg) * ival(b, sg);
    return p[PW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic sg, input logic clr
  );
    int   n;
    logic ok;
    n = 0;
    in_valid  = 1;
    A         = a;
    B         = b;
    is_signed = sg;
    acc_clr   = clr;
    forever begin
      @(negedge clk);
      ok = in_ready;
      step();
      if (ok) break;
      n++;
      if (n > 1000) begin
        checks++;
        failures++;
        $display("FAIL send_timeout: in_ready low for %0d cycles, need 1", n);
        break;
      end
    end
    in_valid = 0;
    acc_clr  = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (C !== '0) begin
      failures++;
      $display("FAIL reset_c: got %0d want 0", C);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
`ifdef CSM_ACCUM_EN
    checks++;
    if (ACC !== '0) begin
      failures++;
      $display("FAIL reset_acc: got %0d want 0", ACC);
    end
`endif
    step();
  endtask

  task automatic test_latency();
    int n0;
    int s1, s3, s9;
    logic [PW-1:0] c1, c3, c9;
    s1 = -1; s3 = -1; s9 = -1;
    c1 = '0; c3 = '0; c9 = '0;
    out_ready = 1;
    n0 = cyc;
    in_valid = 1; A = 7; B = 13; is_signed = 0;
    l_valid = 1; l_a = 7; l_b = 13;
    step();
    in_valid = 0;
    l_valid = 0;
    repeat (15) begin
      @(negedge clk);
      if (l1_ov && s1 < 0) begin s1 = cyc; c1 = l1_c; end
      if (out_valid && s3 < 0) begin s3 = cyc; c3 = C; end
      if (l9_ov && s9 < 0) begin s9 = cyc; c9 = l9_c; end
    end
    step();
    checks++;
    if (s1 - n0 !== 1) begin
      failures++;
      $display("FAIL latency_p1: got %0d want 1", s1 - n0);
    end
    checks++;
    if (s3 - n0 !== 3) begin
      failures++;
      $display("FAIL latency_p3: got %0d want 3", s3 - n0);
    end
    checks++;
    if (s9 - n0 !== 9) begin
      failures++;
      $display("FAIL latency_p9: got %0d want 9", s9 - n0);
    end
    checks++;
    if (c1 !== 18'd91 || c3 !== 18'd91 || c9 !== 18'd91) begin
      failures++;
      $display("FAIL latency_c: got %0d %0d %0d want 91", c1, c3, c9);
    end
  endtask

  task automatic run_and_compare(
    input string name, input logic [PW-1:0] exp[$], input logic b2b
  );
    repeat (P + 4) step();
    checks++;
    if (got.size() !== exp.size()) begin
      failures++;
      $display("FAIL %s_count: got %0d want %0d", name, got.size(), exp.size());
    end
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      checks++;
      if (got[i].c !== exp[i]) begin
        failures++;
        $display("FAIL %s_value[%0d]: got %0h want %0h", name, i, got[i].c, exp[i]);
      end
    end
    if (b2b && got.size() > 0) begin
      checks++;
      if (got[$].cyc - got[0].cyc !== exp.size() - 1) begin
        failures++;
        $display("FAIL %s_throughput: span %0d want %0d",
                 name, got[$].cyc - got[0].cyc, exp.size() - 1);
      end
    end
  endtask

  task automatic test_unsigned();
    logic [W-1:0]  ta[6] = '{0, 511, 511, 1, 256, 511};
    logic [W-1:0]  tb[6] = '{0, 511, 1, 511, 2, 0};
    logic [PW-1:0] exp[$];
    logic [W-1:0]  a, b;
    got.delete();
    out_ready = 1;
    for (int i = 0; i < 2506; i++) begin
      if (i < 6) begin
        a = ta[i]; b = tb[i];
      end else begin
        a = W'($urandom_range(0, 511));
        b = W'($urandom_range(0, 511));
      end
      exp.push_back(ref_mul(a, b, 0));
      send(a, b, 0, 0);
    end
    run_and_compare("unsigned", exp, 1);
  endtask

  task automatic test_signed();
    logic [W-1:0]  ca[4] = '{9'h100, 9'h100, 9'h1FF, 9'h000};
    logic [W-1:0]  cb[4] = '{9'h100, 9'h0FF, 9'h1FF, 9'h100};
    logic [PW-1:0] ce[4] = '{18'd65536, 18'd196864, 18'd1, 18'd0};
    logic [PW-1:0] exp[$];
    logic [W-1:0]  a, b;
    got.delete();
    for (int i = 0; i < 4; i++) begin
      exp.push_back(ce[i]);
      send(ca[i], cb[i], 1, 0);
    end
    for (int i = 0; i < 500; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      exp.push_back(ref_mul(a, b, 1));
      send(a, b, 1, 0);
    end
    run_and_compare("signed", exp, 1);
  endtask

  task automatic test_mixed();
    logic [PW-1:0] exp[$];
    logic [W-1:0]  a, b;
    logic          sg;
    got.delete();
    for (int i = 0; i < 800; i++) begin
      a  = W'($urandom);
      b  = W'($urandom);
      sg = 1'($urandom_range(0, 1));
      exp.push_back(ref_mul(a, b, sg));
      if ($urandom_range(0, 3) == 0) step();
      send(a, b, sg, 0);
    end
    run_and_compare("mixed", exp, 0);
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] exp[$];
    got.delete();
    for (int k = 1; k <= 20; k++) exp.push_back(PW'(k * k));
    rand_rdy = 1;
    fork
      begin
        for (int k = 1; k <= 20; k++) send(W'(k), W'(k), 0, 0);
      end
      begin
        logic          pv, pr;
        logic [PW-1:0] pc;
        pv = 0; pr = 1; pc = '0;
        repeat (300) begin
          @(negedge clk);
          if (pv && !pr) begin
            checks++;
            if (out_valid !== 1'b1 || C !== pc) begin
              failures++;
              $display("FAIL stall_hold: got v=%b c=%0d want v=1 c=%0d",
                       out_valid, C, pc);
            end
          end
          pv = out_valid; pr = out_ready; pc = C;
        end
      end
    join
    @(posedge clk);
    #3;
    rand_rdy  = 0;
    out_ready = 1;
    run_and_compare("backpressure", exp, 0);
  endtask

  task automatic test_reset_midflight();
    got.delete();
    out_ready = 0;
    send(2, 3, 0, 0);
    send(4, 5, 0, 0);
    send(6, 7, 0, 0);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL midflight_full: out_valid got %b want 1", out_valid);
    end
    rst = 1;
    step();
    rst = 0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || C !== '0) begin
      failures++;
      $display("FAIL midflight_flush: got v=%b c=%0d want v=0 c=0", out_valid, C);
    end
    step();
    out_ready = 1;
    repeat (8) step();
    checks++;
    if (got.size() !== 0) begin
      failures++;
      $display("FAIL midflight_stale: got %0d results want 0", got.size());
    end
    send(5, 6, 0, 0);
    repeat (P + 3) step();
    checks++;
    if (got.size() !== 1 || got[0].c !== 18'd30) begin
      failures++;
      $display("FAIL midflight_new: got n=%0d c=%0d want n=1 c=30",
               got.size(), got.size() > 0 ? got[0].c : '0);
    end
  endtask

`ifdef CSM_ACCUM_EN
  task automatic test_accum();
    logic [W-1:0] sa[4] = '{3, 2, 9'h1FF, 1};
    logic [W-1:0] sb[4] = '{4, 5, 7, 1};
    logic         ss[4] = '{0, 0, 1, 0};
    logic         sc[4] = '{1, 0, 0, 1};
    int           se[4] = '{12, 22, 15, 1};
    longint       m;
    logic [W-1:0] a, b;
    logic         sg, clr;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      send(sa[i], sb[i], ss[i], sc[i]);
      repeat (P + 2) step();
      checks++;
      if (ACC !== 24'(se[i])) begin
        failures++;
        $display("FAIL accum_seq[%0d]: got %0d want %0d", i, ACC, se[i]);
      end
    end
    m = 0;
    for (int i = 0; i < 65; i++) begin
      send(511, 511, 0, i == 0);
      m = (m + 261121) % (longint'(1) << 24);
    end
    repeat (P + 2) step();
    checks++;
    if (ACC !== 24'(m)) begin
      failures++;
      $display("FAIL accum_wrap: got %0d want %0d", ACC, m);
    end
    for (int i = 0; i < 40; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      sg  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 9) == 0);
      m   = ((clr ? 0 : m) + ival(a, sg) * ival(b, sg)) & 64'hFFFFFF;
      send(a, b, sg, clr);
    end
    repeat (P + 2) step();
    checks++;
    if (ACC !== 24'(m)) begin
      failures++;
      $display("FAIL accum_random: got %0d want %0d", ACC, m);
    end
  endtask
`endif

  initial begin
    rst = 1; in_valid = 0; A = 0; B = 0; is_signed = 0; acc_clr = 0;
    out_ready = 1; l_valid = 0; l_a = 0; l_b = 0; rand_rdy = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    test_reset();
    test_latency();
    test_unsigned();
    test_signed();
    test_mixed();
    test_backpressure();
    test_reset_midflight();
`ifdef CSM_ACCUM_EN
    test_accum();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
